// File: rtl/bk_addsub_pipe_if.sv
// rtl/bk_addsub_pipe_if.sv - operation and result handshake bundle for bk_addsub_pipe
interface bk_addsub_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, cin, sub, in_tag, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, out_tag
  );

  modport slave (
    input  in_valid, a, b, cin, sub, in_tag, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, out_tag
  );
endinterface

// File: rtl/bk_addsub_pipe.sv
// rtl/bk_addsub_pipe.sv - pipelined group Brent-Kung adder/subtractor with valid/ready flow control
module bk_addsub_pipe #(
  parameter int WIDTH  = 64,
  parameter int GROUP  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic             clk,
  input logic             rst_n,
  bk_addsub_pipe_if.slave bus
);
  localparam int NG  = WIDTH / GROUP;
  localparam int LG  = (NG > 1) ? $clog2(NG) : 0;
  localparam int NGP = 1 << LG;
  localparam int MSB = WIDTH - 1;

  typedef logic [NGP-1:0] gvec_t;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] ld;
  logic [STAGES:0]   rdy;

  // A stage may load when it is empty or its successor is loading this cycle.
  always_comb begin
    rdy[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !vld[k] || rdy[k+1];
  end

  always_comb begin
    vin[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) vin[k] = vld[k-1];
    ld = vin & rdy[STAGES-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) vld[k] <= vin[k];
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[STAGES-1];

  logic [WIDTH-1:0] x1_b;
  logic             x1_c;
  gvec_t            x1_g, x1_p;

  always_comb begin
    x1_b = bus.sub ? ~bus.b : bus.b;
    x1_c = bus.sub ^ bus.cin;
    x1_g = '0;
    x1_p = '0;
    for (int k = 0; k < NG; k++) begin
      x1_p[k] = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        x1_g[k] = (bus.a[k*GROUP+j] & x1_b[k*GROUP+j])
                | ((bus.a[k*GROUP+j] ^ x1_b[k*GROUP+j]) & x1_g[k]);
        x1_p[k] = x1_p[k] & (bus.a[k*GROUP+j] ^ x1_b[k*GROUP+j]);
      end
    end
  end

  logic [WIDTH-1:0] y1_a, y1_b;
  logic             y1_c;
  logic [TAG_W-1:0] y1_tag;
  gvec_t            y1_g, y1_p;

  generate
    if (STAGES >= 2) begin : g_gp_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y1_a   <= '0;
          y1_b   <= '0;
          y1_c   <= 1'b0;
          y1_tag <= '0;
          y1_g   <= '0;
          y1_p   <= '0;
        end else if (ld[0]) begin
          y1_a   <= bus.a;
          y1_b   <= x1_b;
          y1_c   <= x1_c;
          y1_tag <= bus.in_tag;
          y1_g   <= x1_g;
          y1_p   <= x1_p;
        end
      end
    end else begin : g_gp_pass
      assign y1_a   = bus.a;
      assign y1_b   = x1_b;
      assign y1_c   = x1_c;
      assign y1_tag = bus.in_tag;
      assign y1_g   = x1_g;
      assign y1_p   = x1_p;
    end
  endgenerate

  gvec_t x2_g, x2_p;

  // Up-sweep: node i at level d absorbs the span ending at i - 2^d.
  always_comb begin
    x2_g = y1_g;
    x2_p = y1_p;
    for (int d = 0; d < LG; d++) begin
      for (int i = (1 << d); i < NGP; i++) begin
        if (((i + 1) % (1 << (d + 1))) == 0) begin
          x2_g[i] = x2_g[i] | (x2_p[i] & x2_g[i-(1<<d)]);
          x2_p[i] = x2_p[i] & x2_p[i-(1<<d)];
        end
      end
    end
  end

  logic [WIDTH-1:0] y2_a, y2_b;
  logic             y2_c;
  logic [TAG_W-1:0] y2_tag;
  gvec_t            y2_g, y2_p;

  generate
    if (STAGES == 3) begin : g_up_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y2_a   <= '0;
          y2_b   <= '0;
          y2_c   <= 1'b0;
          y2_tag <= '0;
          y2_g   <= '0;
          y2_p   <= '0;
        end else if (ld[1]) begin
          y2_a   <= y1_a;
          y2_b   <= y1_b;
          y2_c   <= y1_c;
          y2_tag <= y1_tag;
          y2_g   <= x2_g;
          y2_p   <= x2_p;
        end
      end
    end else begin : g_up_pass
      assign y2_a   = y1_a;
      assign y2_b   = y1_b;
      assign y2_c   = y1_c;
      assign y2_tag = y1_tag;
      assign y2_g   = x2_g;
      assign y2_p   = x2_p;
    end
  endgenerate

  gvec_t            pg, pp;
  logic [NG-1:0]    gc;
  logic [WIDTH-1:0] x3_sum;
  logic             x3_cout, x3_ovf, x3_zero;
  logic             cc;

  always_comb begin
    pg = y2_g;
    pp = y2_p;
    // Down-sweep fills the odd-position prefixes from the up-sweep spine.
    for (int d = LG - 2; d >= 0; d--) begin
      for (int i = (1 << d); i < NGP; i++) begin
        if ((((i + 1) % (1 << (d + 1))) == (1 << d)) && ((i + 1) > (1 << (d + 1)))) begin
          pg[i] = pg[i] | (pp[i] & pg[i-(1<<d)]);
          pp[i] = pp[i] & pp[i-(1<<d)];
        end
      end
    end
    gc[0] = y2_c;
    for (int k = 1; k < NG; k++) gc[k] = pg[k-1] | (pp[k-1] & y2_c);
    x3_sum = '0;
    cc     = 1'b0;
    for (int k = 0; k < NG; k++) begin
      cc = gc[k];
      for (int j = 0; j < GROUP; j++) begin
        x3_sum[k*GROUP+j] = y2_a[k*GROUP+j] ^ y2_b[k*GROUP+j] ^ cc;
        cc = (y2_a[k*GROUP+j] & y2_b[k*GROUP+j])
           | ((y2_a[k*GROUP+j] ^ y2_b[k*GROUP+j]) & cc);
      end
    end
    x3_cout = pg[NG-1] | (pp[NG-1] & y2_c);
    x3_ovf  = (y2_a[MSB] == y2_b[MSB]) && (x3_sum[MSB] != y2_a[MSB]);
    x3_zero = (x3_sum == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum     <= '0;
      bus.cout    <= 1'b0;
      bus.ovf     <= 1'b0;
      bus.zero    <= 1'b0;
      bus.out_tag <= '0;
    end else if (ld[STAGES-1]) begin
      bus.sum     <= x3_sum;
      bus.cout    <= x3_cout;
      bus.ovf     <= x3_ovf;
      bus.zero    <= x3_zero;
      bus.out_tag <= y2_tag;
    end
  end
endmodule

// File: tb/tb_bk_addsub_pipe.sv
// tb/tb_bk_addsub_pipe.sv - randomized scoreboard bench for bk_addsub_pipe across several configurations
module tb_bk_addsub_pipe;
  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bk_addsub_pipe_if #(.WIDTH(64), .TAG_W(4)) m0 ();
  bk_addsub_pipe_if #(.WIDTH(16), .TAG_W(4)) m1 ();
  bk_addsub_pipe_if #(.WIDTH(64), .TAG_W(4)) m2 ();
  bk_addsub_pipe_if #(.WIDTH(16), .TAG_W(4)) m3 ();

  bk_addsub_pipe #(.WIDTH(64), .GROUP(8), .STAGES(2), .TAG_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(m0.slave));
  bk_addsub_pipe #(.WIDTH(16), .GROUP(1), .STAGES(1), .TAG_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(m1.slave));
  bk_addsub_pipe #(.WIDTH(64), .GROUP(2), .STAGES(3), .TAG_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(m2.slave));
  bk_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(3), .TAG_W(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(m3.slave));

  exp_t       obs [4];
  logic [3:0] ov, ir;
  exp_t       q [4][$];

  assign obs[0] = {m0.sum, m0.cout, m0.ovf, m0.zero, m0.out_tag};
  assign obs[1] = {48'd0, m1.sum, m1.cout, m1.ovf, m1.zero, m1.out_tag};
  assign obs[2] = {m2.sum, m2.cout, m2.ovf, m2.zero, m2.out_tag};
  assign obs[3] = {48'd0, m3.sum, m3.cout, m3.ovf, m3.zero, m3.out_tag};
  assign ov = {m3.out_valid, m2.out_valid, m1.out_valid, m0.out_valid};
  assign ir = {m3.in_ready, m2.in_ready, m1.in_ready, m0.in_ready};

  function automatic int stg(input int d);
    case (d)
      0: return 2;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int wid(input int d);
    return (d == 0 || d == 2) ? 64 : 16;
  endfunction

  // Reference: unsigned wrap for sum/cout, true signed value range for overflow.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub, input logic [3:0] tag);
    exp_t r;
    logic [63:0] mask;
    logic [64:0] full;
    logic signed [65:0] sa, sb, sr, lim;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a = a & mask;
    b = b & mask;
    if (sub) begin
      full   = {1'b0, a} - {1'b0, b} - {64'd0, cin};
      r.cout = ({1'b0, a} >= ({1'b0, b} + {64'd0, cin}));
    end else begin
      full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      r.cout = full[w];
    end
    r.sum  = full[63:0] & mask;
    r.zero = (r.sum == 64'd0);
    sa = $signed({2'b00, a});
    if (a[w-1]) sa = sa - (66'sd1 <<< w);
    sb = $signed({2'b00, b});
    if (b[w-1]) sb = sb - (66'sd1 <<< w);
    sr  = sub ? (sa - sb - $signed({65'd0, cin})) : (sa + sb + $signed({65'd0, cin}));
    lim = 66'sd1 <<< (w - 1);
    r.ovf = (sr >= lim) || (sr < -lim);
    r.tag = tag;
    return r;
  endfunction

  function automatic logic [63:0] rnd();
    case ($urandom_range(0, 9))
      0: return {64{1'b1}};
      1: return 64'd0;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return {$urandom, 16'h0000, 16'h7FFF};
      5: return {$urandom, 16'h0000, 16'h8000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue_and_wait(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                input logic sub, input logic [3:0] tag, output int lat);
    @(negedge clk);
    m0.in_valid = 1'b1; m0.a = a; m0.b = b; m0.cin = cin; m0.sub = sub; m0.in_tag = tag;
    m0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    m0.in_valid = 1'b0; m0.a = {$urandom, $urandom}; m0.b = {$urandom, $urandom};
    m0.cin = ~cin; m0.sub = ~sub; m0.in_tag = ~tag;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (m0.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (m0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m0.out_valid); end
    checks++; if (obs[0] !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs[0]); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (m0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", m0.in_ready); end
    checks++; if (ov !== 4'b0000) begin errors++; $display("FAIL reset_no_output got %b want 0000", ov); end
  endtask

  task automatic test_add_carry();
    int lat;
    issue_and_wait({64{1'b1}}, 64'd1, 1'b0, 1'b0, 4'h3, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
    checks++; if (obs[0] !== {64'd0, 1'b1, 1'b0, 1'b1, 4'h3}) begin errors++; $display("FAIL add_carry got %h want %h", obs[0], {64'd0, 1'b1, 1'b0, 1'b1, 4'h3}); end
  endtask

  task automatic test_signed_ovf();
    int lat;
    issue_and_wait(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'h6, lat);
    checks++; if (obs[0] !== {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 4'h6}) begin errors++; $display("FAIL signed_ovf got %h want %h", obs[0], {64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 4'h6}); end
  endtask

  task automatic test_sub_borrow();
    int lat;
    issue_and_wait(64'd5, 64'd7, 1'b0, 1'b1, 4'h1, lat);
    checks++; if (obs[0] !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'h1}) begin errors++; $display("FAIL sub_borrow got %h want %h", obs[0], {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'h1}); end
    issue_and_wait(64'd7, 64'd5, 1'b1, 1'b1, 4'h2, lat);
    checks++; if (obs[0] !== {64'd1, 1'b1, 1'b0, 1'b0, 4'h2}) begin errors++; $display("FAIL sub_borrow_in got %h want %h", obs[0], {64'd1, 1'b1, 1'b0, 1'b0, 4'h2}); end
    issue_and_wait(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 4'hA, lat);
    checks++; if (obs[0] !== {64'd0, 1'b1, 1'b0, 1'b1, 4'hA}) begin errors++; $display("FAIL sub_zero got %h want %h", obs[0], {64'd0, 1'b1, 1'b0, 1'b1, 4'hA}); end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, blocked = 0;
    logic [63:0] a, b;
    logic cin, sub;
    q[0].delete();
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      if (m0.out_valid) begin
        checks++;
        if (q[0].size() == 0) begin errors++; $display("FAIL bp_spurious got %h want none", obs[0]); end
        else if (obs[0] !== q[0][0]) begin errors++; $display("FAIL bp_result got %h want %h", obs[0], q[0][0]); end
      end
      m0.out_ready = !(cyc >= 4 && cyc < 9);
      if (m0.out_valid && m0.out_ready) begin
        if (q[0].size() > 0) void'(q[0].pop_front());
        got++;
      end
      m0.in_valid = (sent < 8) && (cyc != 2);
      a = rnd(); b = rnd(); cin = 1'($urandom); sub = 1'($urandom);
      m0.a = a; m0.b = b; m0.cin = cin; m0.sub = sub; m0.in_tag = 4'(sent);
      #1;
      if (m0.in_valid && m0.in_ready) begin
        q[0].push_back(model(64, a, b, cin, sub, 4'(sent)));
        sent++;
      end else if (m0.in_valid) begin
        blocked++;
      end
    end
    m0.in_valid = 1'b0;
    m0.out_ready = 1'b1;
    checks++; if (got !== 8) begin errors++; $display("FAIL bp_count got %0d want 8", got); end
    checks++; if (blocked == 0) begin errors++; $display("FAIL bp_in_ready_drop got %0d blocked cycles want >0", blocked); end
  endtask

  task automatic test_throughput();
    logic [63:0] a, b;
    logic cin, sub;
    for (int d = 0; d < 4; d++) q[d].delete();
    m0.out_ready = 1'b1; m1.out_ready = 1'b1; m2.out_ready = 1'b1; m3.out_ready = 1'b1;
    for (int c = 0; c < 104; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (ov[d] !== ((c >= stg(d)) && (c <= 99 + stg(d)))) begin
          errors++; $display("FAIL tp_valid dut%0d cycle %0d got %b want %b", d, c, ov[d], (c >= stg(d)) && (c <= 99 + stg(d)));
        end
        if (ov[d]) begin
          checks++;
          if (q[d].size() == 0) begin errors++; $display("FAIL tp_spurious dut%0d got %h want none", d, obs[d]); end
          else begin
            if (obs[d] !== q[d][0]) begin errors++; $display("FAIL tp_result dut%0d got %h want %h", d, obs[d], q[d][0]); end
            void'(q[d].pop_front());
          end
        end
      end
      if (c < 100) begin
        a = rnd(); b = rnd(); cin = 1'($urandom); sub = 1'($urandom);
        m0.a = a;       m0.b = b;       m2.a = a;       m2.b = b;
        m1.a = a[15:0]; m1.b = b[15:0]; m3.a = a[15:0]; m3.b = b[15:0];
        m0.cin = cin; m1.cin = cin; m2.cin = cin; m3.cin = cin;
        m0.sub = sub; m1.sub = sub; m2.sub = sub; m3.sub = sub;
        m0.in_tag = 4'(c); m1.in_tag = 4'(c); m2.in_tag = 4'(c); m3.in_tag = 4'(c);
        m0.in_valid = 1'b1; m1.in_valid = 1'b1; m2.in_valid = 1'b1; m3.in_valid = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
          checks++;
          if (ir[d] !== 1'b1) begin errors++; $display("FAIL tp_in_ready dut%0d cycle %0d got %b want 1", d, c, ir[d]); end
          else q[d].push_back(model(wid(d), a, b, cin, sub, 4'(c)));
        end
      end else begin
        m0.in_valid = 1'b0; m1.in_valid = 1'b0; m2.in_valid = 1'b0; m3.in_valid = 1'b0;
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (q[d].size() != 0) begin errors++; $display("FAIL tp_drain dut%0d got %0d left want 0", d, q[d].size()); end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    m0.out_ready = 1'b0; m0.in_valid = 1'b1;
    m0.a = {64{1'b1}}; m0.b = 64'd2; m0.cin = 1'b0; m0.sub = 1'b0; m0.in_tag = 4'h9;
    @(negedge clk);
    m0.a = 64'h10; m0.b = 64'h20; m0.in_tag = 4'hA;
    @(negedge clk);
    m0.in_valid = 1'b0;
    checks++; if (m0.out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", m0.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", m0.out_valid); end
    checks++; if (obs[0] !== '0) begin errors++; $display("FAIL rst_mid_outputs got %h want 0", obs[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    m0.out_ready = 1'b1;
    #1;
    checks++; if (m0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", m0.in_ready); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (m0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale cycle %0d got %b want 0", k, m0.out_valid); end
    end
  endtask

  initial begin
    m0.in_valid = 1'b0; m0.a = '0; m0.b = '0; m0.cin = 1'b0; m0.sub = 1'b0; m0.in_tag = '0; m0.out_ready = 1'b1;
    m1.in_valid = 1'b0; m1.a = '0; m1.b = '0; m1.cin = 1'b0; m1.sub = 1'b0; m1.in_tag = '0; m1.out_ready = 1'b1;
    m2.in_valid = 1'b0; m2.a = '0; m2.b = '0; m2.cin = 1'b0; m2.sub = 1'b0; m2.in_tag = '0; m2.out_ready = 1'b1;
    m3.in_valid = 1'b0; m3.a = '0; m3.b = '0; m3.cin = 1'b0; m3.sub = 1'b0; m3.in_tag = '0; m3.out_ready = 1'b1;
    test_reset();
    test_add_carry();
    test_signed_ovf();
    test_sub_borrow();
    test_backpressure();
    test_throughput();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
